missile_position: RTL and testbench

//  Horizontal position counter for one missile object; produces the one-clock

---
 rtl/missile_position_if.sv | 36 +++
 rtl/missile_position.sv | 69 ++++++
 tb/tb_missile_position.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/missile_position_if.sv
// missile_position_if: register-file side bundle for one missile position counter
// Signals (master = TIA register file / beam timing, slave = missile_position):
//   pixel_enable  colour-clock tick
//   hblank        horizontal blank
//   resp          RESMx write strobe
//   hm_write      HMMx write strobe, latches motion
//   motion[3:0]   signed HMMx value, positive moves left
//   hmove         HMOVE strobe
//   hmclr         HMCLR strobe
//   copies[2:0]   NUSIZ copy field
//   strobe        start pulse to the missile renderer (slave output)
//   resmp, player_center  only when MISSILE_RESMP_EN is defined
interface missile_position_if;
    logic       pixel_enable;
    logic       hblank;
    logic       resp;
    logic       hm_write;
    logic [3:0] motion;
    logic       hmove;
    logic       hmclr;
    logic [2:0] copies;
    logic       strobe;
`ifdef MISSILE_RESMP_EN
    logic       resmp;
    logic       player_center;
    modport master (output pixel_enable, hblank, resp, hm_write, motion, hmove, hmclr, copies,
                    resmp, player_center, input strobe);
    modport slave  (input pixel_enable, hblank, resp, hm_write, motion, hmove, hmclr, copies,
                    resmp, player_center, output strobe);
`else
    modport master (output pixel_enable, hblank, resp, hm_write, motion, hmove, hmclr, copies,
                    input strobe);
    modport slave  (input pixel_enable, hblank, resp, hm_write, motion, hmove, hmclr, copies,
                    output strobe);
`endif
endinterface

// File: rtl/missile_position.sv
// missile_position: horizontal position counter and start strobe for one missile
// Ports:
//   clk    system clock
//   reset  asynchronous active-high reset
//   bus    missile_position_if.slave (ticks, blanking, RESMx, HMMx/HMOVE/HMCLR, NUSIZ, strobe)
// Optional feature macro MISSILE_RESMP_EN: while bus.resmp is high the strobe is
// suppressed, the counter holds and reloads 0 on each bus.player_center pulse.
module missile_position #(
    parameter int LINE_PIXELS  = 160,
    parameter int COUNTER_BITS = 8
) (
    input logic               clk,
    input logic               reset,
    missile_position_if.slave bus
);
    localparam logic [COUNTER_BITS-1:0] LAST = COUNTER_BITS'(LINE_PIXELS - 1);
    localparam logic [COUNTER_BITS-1:0] ONE  = COUNTER_BITS'(1);
    localparam logic [COUNTER_BITS-1:0] P16  = COUNTER_BITS'(16);
    localparam logic [COUNTER_BITS-1:0] P32  = COUNTER_BITS'(32);
    localparam logic [COUNTER_BITS-1:0] P64  = COUNTER_BITS'(64);
    logic [COUNTER_BITS-1:0] cnt, cnt_inc, cnt_dec;
    logic signed [3:0]       motion_reg;
    logic signed [4:0]       pending;
    logic                    strobe_r, visible, step, start, hold, center;
`ifdef MISSILE_RESMP_EN
    assign hold   = bus.resmp;
    assign center = bus.player_center;
`else
    assign hold   = 1'b0;
    assign center = 1'b0;
`endif
    assign cnt_inc = (cnt == LAST) ? '0 : cnt + ONE;
    assign cnt_dec = (cnt == '0) ? LAST : cnt - ONE;
    assign visible = bus.pixel_enable & ~bus.hblank;
    // motion steps only in blank; a same-cycle RESMx, HMOVE or RESMP hold wins over a step
    assign step    = bus.pixel_enable & bus.hblank & (pending != '0) & ~bus.resp & ~bus.hmove & ~hold;
    // start test uses the value the counter is about to take
    assign start   = (cnt_inc == '0)
                   | ((cnt_inc == P16) & (bus.copies == 3'b001 | bus.copies == 3'b011))
                   | ((cnt_inc == P32) & (bus.copies == 3'b010 | bus.copies == 3'b011 | bus.copies == 3'b110))
                   | ((cnt_inc == P64) & (bus.copies == 3'b100 | bus.copies == 3'b110));
    assign bus.strobe = strobe_r;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            motion_reg <= '0;
            pending    <= '0;
            strobe_r   <= 1'b0;
        end else begin
            if (hold)
                cnt <= center ? '0 : cnt;
            else if (bus.resp)
                cnt <= '0;
            else if (visible)
                cnt <= cnt_inc;
            else if (step)
                cnt <= pending[4] ? cnt_dec : cnt_inc;
            if (bus.hmove)
                pending <= {motion_reg[3], motion_reg};
            else if (step)
                pending <= pending[4] ? pending + 5'sd1 : pending - 5'sd1;
            if (bus.hmclr)
                motion_reg <= '0;
            else if (bus.hm_write)
                motion_reg <= $signed(bus.motion);
            strobe_r <= visible & ~bus.resp & ~hold & start;
        end
    end
endmodule

// File: tb/tb_missile_position.sv
// tb_missile_position: randomized self-checking bench for missile_position
module tb_missile_position;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    missile_position_if bus();
    missile_position dut (.clk(clk), .reset(reset), .bus(bus));

    int   n_cmp = 0;
    int   n_bad = 0;
    int   pos, mreg, pend;
    logic exp_strobe;

    function automatic bit is_start(input int p, input logic [2:0] c);
        int s[$];
        case (c)
            3'b001:  s = {0, 16};
            3'b010:  s = {0, 32};
            3'b011:  s = {0, 16, 32};
            3'b100:  s = {0, 64};
            3'b110:  s = {0, 32, 64};
            default: s = {0};
        endcase
        foreach (s[i]) if (s[i] == p) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        pos = 0; mreg = 0; pend = 0; exp_strobe = 1'b0;
    endtask

    // one clock of stimulus; reference model advanced from the line-position rules
    task automatic drive(input logic pe, input logic hb, input logic rs, input logic hw,
                         input logic [3:0] mo, input logic hm, input logic hc);
        logic s;
        bus.pixel_enable = pe; bus.hblank = hb; bus.resp = rs; bus.hm_write = hw;
        bus.motion = mo; bus.hmove = hm; bus.hmclr = hc;
        @(posedge clk);
        #1;
        s = 1'b0;
        if (rs) pos = 0;
        else if (pe && !hb) begin
            pos = (pos + 1) % 160;
            s = is_start(pos, bus.copies);
        end else if (pe && hb && pend != 0 && !hm) begin
            if (pend > 0) begin pos = (pos + 1) % 160; pend--; end
            else begin pos = (pos + 159) % 160; pend++; end
        end
        if (hm) pend = mreg;
        if (hc) mreg = 0;
        else if (hw) mreg = int'($signed(mo));
        exp_strobe = s;
        bus.pixel_enable = 1'b0; bus.resp = 1'b0; bus.hm_write = 1'b0;
        bus.hmove = 1'b0; bus.hmclr = 1'b0;
    endtask

    task automatic vis();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.pixel_enable = 0; bus.hblank = 0; bus.resp = 0; bus.hm_write = 0;
        bus.motion = 0; bus.hmove = 0; bus.hmclr = 0; bus.copies = 0;
`ifdef MISSILE_RESMP_EN
        bus.resmp = 0; bus.player_center = 0;
`endif
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.strobe !== 1'b0) begin
            n_bad++; $display("FAIL reset strobe=%b expected 0", bus.strobe);
        end
        @(negedge clk) reset = 1'b0;
        model_reset();
    endtask

    task automatic test_count();
        int first, hits;
        first = 0; hits = 0;
        bus.copies = 3'b000;
        for (int t = 1; t <= 200; t++) begin
            repeat ($urandom_range(0, 2)) begin
                drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
                n_cmp++;
                if (bus.strobe !== exp_strobe) begin
                    n_bad++; $display("FAIL count_idle t=%0d strobe=%b expected %b", t, bus.strobe, exp_strobe);
                end
            end
            vis();
            n_cmp++;
            if (bus.strobe !== exp_strobe) begin
                n_bad++; $display("FAIL count t=%0d strobe=%b expected %b", t, bus.strobe, exp_strobe);
            end
            if (bus.strobe === 1'b1) begin hits++; if (first == 0) first = t; end
        end
        n_cmp++;
        if (first != 160 || hits != 1) begin
            n_bad++; $display("FAIL count_first first=%0d hits=%0d expected 160/1", first, hits);
        end
        first = 0;
        for (int t = 1; t <= 130; t++) begin
            vis();
            n_cmp++;
            if (bus.strobe !== exp_strobe) begin
                n_bad++; $display("FAIL count40 t=%0d strobe=%b expected %b", t, bus.strobe, exp_strobe);
            end
            if (bus.strobe === 1'b1 && first == 0) first = t;
        end
        n_cmp++;
        if (first != 120) begin
            n_bad++; $display("FAIL count40_wrap tick=%0d expected 120", first);
        end
    endtask

    // ticks until the next strobe, checking every cycle against the model
    task automatic run_to_strobe(input string name, input int want);
        int first;
        first = 0;
        for (int t = 1; t <= 170 && first == 0; t++) begin
            vis();
            n_cmp++;
            if (bus.strobe !== exp_strobe) begin
                n_bad++; $display("FAIL %s t=%0d strobe=%b expected %b", name, t, bus.strobe, exp_strobe);
            end
            if (bus.strobe === 1'b1) first = t;
        end
        n_cmp++;
        if (first != want) begin
            n_bad++; $display("FAIL %s_ticks got=%0d expected %0d", name, first, want);
        end
    endtask

    task automatic hb_ticks(input string name, input int n);
        bus.hblank = 1'b1;
        for (int t = 0; t < n; t++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
            n_cmp++;
            if (bus.strobe !== 1'b0 || exp_strobe !== 1'b0) begin
                n_bad++; $display("FAIL %s_step t=%0d strobe=%b expected 0", name, t, bus.strobe);
            end
        end
        bus.hblank = 1'b0;
    endtask

    task automatic test_resp();
        repeat (50) vis();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.strobe !== 1'b0) begin
            n_bad++; $display("FAIL resp_no_strobe strobe=%b expected 0", bus.strobe);
        end
        run_to_strobe("resp", 160);
    endtask

    task automatic test_copies();
        int got[$];
        int want[$];
        want = {16, 32, 160};
        bus.copies = 3'b011;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        for (int t = 1; t <= 160; t++) begin
            vis();
            n_cmp++;
            if (bus.strobe !== exp_strobe) begin
                n_bad++; $display("FAIL copies011 t=%0d strobe=%b expected %b", t, bus.strobe, exp_strobe);
            end
            if (bus.strobe === 1'b1) got.push_back(t);
        end
        n_cmp++;
        if (got != want) begin
            n_bad++; $display("FAIL copies011_set count=%0d expected 3 at 16,32,160", got.size());
        end
        for (int l = 0; l < 4; l++) begin
            bus.copies = 3'($urandom_range(0, 7));
            for (int t = 0; t < 160; t++) begin
                if ($urandom_range(0, 40) == 0) bus.copies = 3'($urandom_range(0, 7));
                vis();
                n_cmp++;
                if (bus.strobe !== exp_strobe) begin
                    n_bad++; $display("FAIL copies_rand c=%0d pos=%0d strobe=%b expected %b", bus.copies, pos, bus.strobe, exp_strobe);
                end
            end
        end
        bus.copies = 3'b000;
    endtask

    task automatic test_motion();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        hb_ticks("move_p3", 10);
        run_to_strobe("move_p3", 157);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        vis(); vis();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 4'b1000, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        hb_ticks("move_m8", 10);
        run_to_strobe("move_m8", 6);
    endtask

    task automatic test_same_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0);
        repeat (30) vis();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.strobe !== 1'b0) begin
            n_bad++; $display("FAIL resp_pe strobe=%b expected 0", bus.strobe);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd7, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        hb_ticks("hmclr_hw", 10);
        run_to_strobe("same_cycle", 160);
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        repeat (159) vis();
        vis();
        n_cmp++;
        if (bus.strobe !== 1'b1) begin
            n_bad++; $display("FAIL mid_strobe_high strobe=%b expected 1", bus.strobe);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (bus.strobe !== 1'b0) begin
            n_bad++; $display("FAIL mid_async_drop strobe=%b expected 0", bus.strobe);
        end
        @(negedge clk) reset = 1'b0;
        model_reset();
        hb_ticks("mid_no_motion", 10);
        run_to_strobe("mid_after", 160);
    endtask

    task automatic test_random();
        logic hb;
        hb = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 30) == 0) hb = ~hb;
            if ($urandom_range(0, 99) == 0) bus.copies = 3'($urandom_range(0, 7));
            drive(1'($urandom_range(0, 1)), hb, ($urandom_range(0, 63) == 0),
                  ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 15) == 0), ($urandom_range(0, 31) == 0));
            n_cmp++;
            if (bus.strobe !== exp_strobe) begin
                n_bad++; $display("FAIL random c=%0d pos=%0d strobe=%b expected %b", c, pos, bus.strobe, exp_strobe);
            end
        end
        bus.hblank = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count();
        test_resp();
        test_copies();
        test_motion();
        test_same_cycle();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
